// File: rtl/cam_i2c_byte_master.sv
// Serialises (reg addr, data hi, data lo) byte triplets from a valid/ready stream onto the
// image-sensor I2C bus as one write transaction each, driving open-drain SCL/SDA enables.
module cam_i2c_byte_master #(
   parameter int unsigned CLK_DIV  = 125,
   parameter logic [6:0]  DEV_ADDR = 7'h5D
) (
   input  logic       sysClk,
   input  logic       rst,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   input  logic       last_byte,
   output logic       ready_for_next_byte,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in,
   output logic       busy,
   output logic       nack_err
);

   localparam int unsigned CNT_W = 10;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_SEND, S_ACK, S_GET_BYTE, S_STOP, S_DRAIN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] qcnt;
   logic [1:0]       quarter;
   logic [2:0]       bit_idx;
   logic [1:0]       byte_idx;
   logic [7:0]       shreg;
   logic [7:0]       data_q;
   logic             addr_phase;
   logic             last_q;
   logic             nack_q;
   logic [1:0]       sda_sync;
   logic             tick_c;
   logic             xfer_c;
   logic             waiting_c;

   assign tick_c    = (qcnt == CNT_W'(CLK_DIV - 1));
   assign xfer_c    = byte_valid && ready_for_next_byte;
   assign waiting_c = (state == S_IDLE) || (state == S_GET_BYTE) || (state == S_DRAIN);

   // Quarter-period divider, parked at zero while waiting for the stream
   always_ff @(posedge sysClk or posedge rst) begin
      if (rst)
         qcnt <= '0;
      else if (waiting_c || tick_c)
         qcnt <= '0;
      else
         qcnt <= qcnt + CNT_W'(1);
   end

   always_ff @(posedge sysClk or posedge rst) begin
      if (rst)
         sda_sync <= 2'b11;
      else
         sda_sync <= {sda_sync[0], sda_in};
   end

   always_ff @(posedge sysClk or posedge rst) begin
      if (rst) begin
         state               <= S_IDLE;
         quarter             <= 2'd0;
         bit_idx             <= 3'd0;
         byte_idx            <= 2'd0;
         shreg               <= 8'd0;
         data_q              <= 8'd0;
         addr_phase          <= 1'b0;
         last_q              <= 1'b0;
         nack_q              <= 1'b0;
         scl_oe              <= 1'b0;
         sda_oe              <= 1'b0;
         ready_for_next_byte <= 1'b0;
         busy                <= 1'b0;
         nack_err            <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               scl_oe <= 1'b0;
               sda_oe <= 1'b0;
               if (xfer_c) begin
                  data_q              <= byte_in;
                  byte_idx            <= 2'd1;
                  last_q              <= 1'b0;
                  nack_err            <= 1'b0;
                  quarter             <= 2'd0;
                  ready_for_next_byte <= 1'b0;
                  busy                <= 1'b1;
                  state               <= S_START;
               end else begin
                  ready_for_next_byte <= 1'b1;
                  busy                <= 1'b0;
               end
            end

            // Bus released for one quarter, SDA falls with SCL high, then SCL is pulled low
            S_START: if (tick_c) begin
               quarter <= quarter + 2'd1;
               if (quarter == 2'd0) sda_oe <= 1'b1;
               if (quarter == 2'd1) scl_oe <= 1'b1;
               if (quarter == 2'd2) begin
                  shreg      <= {DEV_ADDR, 1'b0};
                  addr_phase <= 1'b1;
                  bit_idx    <= 3'd0;
                  quarter    <= 2'd0;
                  state      <= S_SEND;
               end
            end

            S_SEND: if (tick_c) begin
               quarter <= quarter + 2'd1;
               if (quarter == 2'd0) sda_oe <= ~shreg[7];
               if (quarter == 2'd1) scl_oe <= 1'b0;
               if (quarter == 2'd3) begin
                  scl_oe  <= 1'b1;
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= S_ACK;
               end
            end

            S_ACK: if (tick_c) begin
               quarter <= quarter + 2'd1;
               if (quarter == 2'd0) sda_oe <= 1'b0;
               if (quarter == 2'd1) scl_oe <= 1'b0;
               if (quarter == 2'd2) nack_q <= sda_sync[1];
               if (quarter == 2'd3) begin
                  scl_oe <= 1'b1;
                  if (nack_q) begin
                     nack_err <= 1'b1;
                     state    <= S_STOP;
                  end else if (addr_phase) begin
                     addr_phase <= 1'b0;
                     shreg      <= data_q;
                     state      <= S_SEND;
                  end else if (byte_idx == 2'd3) begin
                     state <= S_STOP;
                  end else begin
                     ready_for_next_byte <= 1'b1;
                     state               <= S_GET_BYTE;
                  end
               end
            end

            // SCL stays where it was left; byte_idx 0 means the next byte opens a new triplet
            S_GET_BYTE: begin
               if (xfer_c) begin
                  ready_for_next_byte <= 1'b0;
                  quarter             <= 2'd0;
                  if (byte_idx == 2'd0) begin
                     data_q   <= byte_in;
                     byte_idx <= 2'd1;
                     state    <= S_START;
                  end else begin
                     shreg    <= byte_in;
                     bit_idx  <= 3'd0;
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx == 2'd2) last_q <= last_byte;
                     state    <= S_SEND;
                  end
               end else begin
                  ready_for_next_byte <= 1'b1;
               end
            end

            S_STOP: if (tick_c) begin
               quarter <= quarter + 2'd1;
               if (quarter == 2'd0) sda_oe <= 1'b1;
               if (quarter == 2'd1) scl_oe <= 1'b0;
               if (quarter == 2'd2) sda_oe <= 1'b0;
               if (quarter == 2'd3) begin
                  ready_for_next_byte <= 1'b1;
                  if (last_q) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else if (nack_q) begin
                     state <= S_DRAIN;
                  end else begin
                     byte_idx <= 2'd0;
                     state    <= S_GET_BYTE;
                  end
               end
            end

            // After a NACK the rest of the burst is swallowed without touching the bus
            S_DRAIN: begin
               ready_for_next_byte <= 1'b1;
               if (xfer_c && last_byte) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
